// File: rtl/score_disp_pkg.sv
// Shared constants, segment codes and FSM state type for the score display driver.
package score_disp_pkg;

  localparam int unsigned MAX_SCORE  = 9999;
  localparam int unsigned BCD_ITER   = 14;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned VAL_W      = 14;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // Double-dabble pre-shift correction: +3 on every nibble >= 5.
  function automatic logic [4*NUM_DIGITS-1:0] dabble_adj(input logic [4*NUM_DIGITS-1:0] bcd);
    logic [4*NUM_DIGITS-1:0] r;
    r = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_driver_bcd_to_seg7.sv
// BCD digit to active-low 7-segment code; blank_i or a non-decimal code turns all segments off.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (bcd_i)
        4'd0:    seg_n_o = SEG_0;
        4'd1:    seg_n_o = SEG_1;
        4'd2:    seg_n_o = SEG_2;
        4'd3:    seg_n_o = SEG_3;
        4'd4:    seg_n_o = SEG_4;
        4'd5:    seg_n_o = SEG_5;
        4'd6:    seg_n_o = SEG_6;
        4'd7:    seg_n_o = SEG_7;
        4'd8:    seg_n_o = SEG_8;
        4'd9:    seg_n_o = SEG_9;
        default: seg_n_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// Clamps the processor score, converts it to BCD by sequential double-dabble and
// scans it onto a 4-digit common-anode display with leading-zero blanking.
module score_display_driver
  import score_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned MAX_SCORE = score_disp_pkg::MAX_SCORE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] score_in,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        busy,
  output logic        clamped
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  state_e                  state_q, state_d;
  logic [31:0]             last_q, last_d;
  logic [VAL_W-1:0]        bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [3:0]              iter_q, iter_d;
  logic                    busy_q, busy_d;
  logic                    pend_clamp_q, pend_clamp_d;
  logic                    clamped_q, clamped_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;

  logic [VAL_W-1:0]        clamp_val;
  logic                    clamp_flag;
  logic [VAL_W+4*NUM_DIGITS-1:0] shifted;
  logic [3:0]              digit_sel;
  logic                    blank_sel;
  logic [6:0]              seg_dec;

  always_comb begin
    clamp_val  = score_in[VAL_W-1:0];
    clamp_flag = 1'b0;
    if (score_in[31]) begin
      clamp_val  = '0;
      clamp_flag = 1'b1;
    end else if (score_in > 32'(MAX_SCORE)) begin
      clamp_val  = VAL_W'(MAX_SCORE);
      clamp_flag = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    digits_d     = digits_q;
    iter_d       = iter_q;
    busy_d       = busy_q;
    pend_clamp_d = pend_clamp_q;
    clamped_d    = clamped_q;
    shifted      = {dabble_adj(bcd_q), bin_q} << 1;
    unique case (state_q)
      ST_IDLE: begin
        if (score_in != last_q) begin
          last_d       = score_in;
          bin_d        = clamp_val;
          bcd_d        = '0;
          iter_d       = '0;
          busy_d       = 1'b1;
          pend_clamp_d = clamp_flag;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = shifted;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'(BCD_ITER - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d  = bcd_q;
        clamped_d = pend_clamp_q;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A digit is blanked only when it and every more significant digit are zero.
  always_comb begin
    digit_sel = digits_q[{idx_q, 2'b00} +: 4];
    unique case (idx_q)
      2'd1:    blank_sel = (digits_q[15:4]  == '0);
      2'd2:    blank_sel = (digits_q[15:8]  == '0);
      2'd3:    blank_sel = (digits_q[15:12] == '0);
      default: blank_sel = 1'b0;
    endcase
  end

  bcd_to_seg7 u_seg (
    .bcd_i   (digit_sel),
    .blank_i (blank_sel),
    .seg_n_o (seg_dec)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_dec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      digits_q     <= '0;
      iter_q       <= '0;
      busy_q       <= 1'b0;
      pend_clamp_q <= 1'b0;
      clamped_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      digits_q     <= digits_d;
      iter_q       <= iter_d;
      busy_q       <= busy_d;
      pend_clamp_q <= pend_clamp_d;
      clamped_q    <= clamped_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_n   = seg_q;
  assign an_n    = an_q;
  assign busy    = busy_q;
  assign clamped = clamped_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with a queue-based scan scoreboard.
module tb_score_display_driver;

  localparam int unsigned SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] score_in = '0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        busy;
  logic        clamped;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];

  score_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .score_in (score_in),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .busy     (busy),
    .clamped  (clamped)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int unsigned model_val(input logic [31:0] s);
    if (s[31]) return 0;
    if (s > 32'd9999) return 9999;
    return int'(s);
  endfunction

  function automatic logic model_clamp(input logic [31:0] s);
    return s[31] || (s > 32'd9999);
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned v, input int unsigned k);
    int unsigned p;
    p = 10 ** k;
    if (k > 0 && v < p) return 7'h7F;
    return seg_of((v / p) % 10);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"}, seg_n, 7'h7F);
    check({tag, "_an"}, an_n, 4'hF);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_clamped"}, clamped, 1'b0);
  endtask

  // Expects the FSM in IDLE with score_in already differing; the next edge is E0.
  task automatic run_conv(input string tag, input logic [31:0] s);
    step();
    check({tag, "_busy_E0"}, busy, 1'b1);
    repeat (14) step();
    check({tag, "_busy_E14"}, busy, 1'b1);
    step();
    check({tag, "_busy_E15"}, busy, 1'b0);
    check({tag, "_clamped"}, clamped, model_clamp(s));
  endtask

  task automatic scan_check(input string tag, input int unsigned v);
    logic [3:0] prev;
    logic [3:0] an_exp;
    exp_t       e;
    bit         found;
    prev  = an_n;
    found = 1'b0;
    for (int i = 0; i < 8 * SCAN_DIV; i++) begin
      step();
      if (an_n == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = an_n;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sync: observed no digit-0 window start, expected one within %0d cycles", tag, 8 * SCAN_DIV);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      an_exp = ~(4'b0001 << k);
      for (int c = 0; c < int'(SCAN_DIV); c++) begin
        e.an  = an_exp;
        e.seg = exp_seg(v, k);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 4 * int'(SCAN_DIV); i++) begin
      if (i > 0) step();
      e = sb.pop_front();
      check({tag, "_an"}, an_n, e.an);
      check({tag, "_seg"}, seg_n, e.seg);
    end
  endtask

  task automatic conv_and_scan(input string tag, input logic [31:0] s);
    score_in = s;
    run_conv(tag, s);
    scan_check(tag, model_val(s));
  endtask

  initial begin
    int unsigned k;

    #1 reset = 1'b0;
    #1;
    check_reset_vals("rst_init");
    @(posedge clock);
    #1 reset = 1'b1;
    step();
    check("rst_first_an", an_n, 4'b1110);
    check("rst_first_seg", seg_n, 7'h40);
    check("rst_first_busy", busy, 1'b0);

    conv_and_scan("s1234", 32'd1234);
    conv_and_scan("s12345", 32'd12345);
    conv_and_scan("sneg10", 32'hFFFF_FFF6);
    conv_and_scan("s7", 32'd7);
    conv_and_scan("s1005", 32'd1005);

    // Change while busy: 1234 captured at E0, 56 presented before E3.
    score_in = 32'd1234;
    step();
    check("chg_busy_E0", busy, 1'b1);
    step();
    step();
    score_in = 32'd56;
    repeat (13) step();
    check("chg_busy_E15", busy, 1'b0);
    check("chg_clamped", clamped, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) check("chg_recapture", busy, 1'b1);
      k = 0;
      for (int b = 0; b < 4; b++) if (an_n[b] == 1'b0) k = b;
      check("chg_old_seg", seg_n, exp_seg(1234, k));
    end
    check("chg_commit56", busy, 1'b0);
    scan_check("s56", 56);

    // Reset in the middle of a conversion, then recapture.
    score_in = 32'd4321;
    repeat (8) step();
    check("mid_busy_E7", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    step();
    check("rst_mid_held_an", an_n, 4'hF);
    reset = 1'b1;
    run_conv("s4321", 32'd4321);
    scan_check("s4321", 4321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
